// File: rtl/hamming_pkg.sv
// Shared types and Hamming(7,4) parity masks for the syndrome capture front end.
// Bit order of a word: p1=0, p2=1, i0=2, p3=3, i1=4, i2=5, i3=6.
package hamming_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_e;

   localparam logic [6:0] P1_MASK = 7'b1010101;
   localparam logic [6:0] P2_MASK = 7'b1100110;
   localparam logic [6:0] P3_MASK = 7'b1111000;

   // Result is the 1-based position of a single flipped bit, 0 for a codeword.
   function automatic logic [2:0] compute_syndrome(input logic [6:0] word);
      return {^(word & P3_MASK), ^(word & P2_MASK), ^(word & P1_MASK)};
   endfunction

endpackage

// File: rtl/module_switch_synchronizer.sv
// Multi-flop synchroniser that brings the asynchronous switch word into the clk domain.
module module_switch_synchronizer #(
   parameter int SYNC_STAGES = 2,
   parameter int W           = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] d_out
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q;
   logic [SYNC_STAGES-1:0][W-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/module_syndrome_capture.sv
// Debounces the received-word switches, captures a stable word with its syndrome and
// hands it on over valid/ready. Optional error counter: HAMMING_ERROR_COUNT_EN.
//
// state    | meaning
// S_IDLE   | waiting for the synchronised word to differ from the last capture
// S_SETTLE | candidate must stay equal for DEBOUNCE_CYCLES samples
// S_HOLD   | word presented, valid high, waiting for ready
module module_syndrome_capture
   import hamming_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int ERR_CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           switch_raw,
   input  logic                 ready,
   output logic                 valid,
   output logic [6:0]           switch_error,
   output logic [2:0]           sindrome,
   output logic                 error_detected
`ifdef HAMMING_ERROR_COUNT_EN
   ,
   output logic [ERR_CNT_W-1:0] error_count
`endif
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [6:0] sync_out;

   module_switch_synchronizer #(
      .SYNC_STAGES(SYNC_STAGES),
      .W          (7)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_in (switch_raw),
      .d_out(sync_out)
   );

   state_e           state_q, state_d;
   logic [6:0]       cand_q, cand_d;
   logic [6:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic             valid_q, valid_d;
   logic [6:0]       word_q, word_d;
   logic [2:0]       synd_q, synd_d;
   logic             err_q, err_d;
   logic [2:0]       cand_synd;
`ifdef HAMMING_ERROR_COUNT_EN
   logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;
`endif

   assign cand_synd = compute_syndrome(cand_q);

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      valid_d = valid_q;
      word_d  = word_q;
      synd_d  = synd_q;
      err_d   = err_q;
`ifdef HAMMING_ERROR_COUNT_EN
      errcnt_d = errcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sync_out != last_q) begin
               cand_d  = sync_out;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // The post-reset pass must emit even when the word equals last_q (0).
            if (!first_q && (sync_out == last_q)) begin
               state_d = S_IDLE;
            end else if (sync_out != cand_q) begin
               cand_d = sync_out;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               word_d  = cand_q;
               synd_d  = cand_synd;
               err_d   = |cand_synd;
               last_d  = cand_q;
               valid_d = 1'b1;
               first_d = 1'b0;
               state_d = S_HOLD;
`ifdef HAMMING_ERROR_COUNT_EN
               if ((cand_synd != 3'b000) && (errcnt_q != '1)) begin
                  errcnt_d = errcnt_q + 1'b1;
               end
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (valid_q && ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_SETTLE;
         cand_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         first_q <= 1'b1;
         valid_q <= 1'b0;
         word_q  <= '0;
         synd_q  <= '0;
         err_q   <= 1'b0;
`ifdef HAMMING_ERROR_COUNT_EN
         errcnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         valid_q <= valid_d;
         word_q  <= word_d;
         synd_q  <= synd_d;
         err_q   <= err_d;
`ifdef HAMMING_ERROR_COUNT_EN
         errcnt_q <= errcnt_d;
`endif
      end
   end

   assign valid          = valid_q;
   assign switch_error   = word_q;
   assign sindrome       = synd_q;
   assign error_detected = err_q;
`ifdef HAMMING_ERROR_COUNT_EN
   assign error_count    = errcnt_q;
`endif

endmodule

// File: tb/tb_module_syndrome_capture.sv
// Directed bench for module_syndrome_capture with SYNC_STAGES=2, DEBOUNCE_CYCLES=4;
// the error_count sequence is exercised when HAMMING_ERROR_COUNT_EN is defined.
module tb_module_syndrome_capture;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int ERR_CNT_W       = 2;
   localparam int LATENCY         = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] switch_raw = 7'b0;
   logic       ready = 1'b1;
   logic       valid;
   logic [6:0] switch_error;
   logic [2:0] sindrome;
   logic       error_detected;
`ifdef HAMMING_ERROR_COUNT_EN
   logic [ERR_CNT_W-1:0] error_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   module_syndrome_capture #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ERR_CNT_W      (ERR_CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .switch_raw    (switch_raw),
      .ready         (ready),
      .valid         (valid),
      .switch_error  (switch_error),
      .sindrome      (sindrome),
      .error_detected(error_detected)
`ifdef HAMMING_ERROR_COUNT_EN
      ,
      .error_count   (error_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Returns the number of edges until valid is seen, or -1 when the budget runs out.
   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (lat < budget) begin
         @(posedge clk);
         #1;
         lat++;
         if (valid) return;
      end
      lat = -1;
   endtask

   task automatic expect_capture(input string tag, input logic [6:0] word,
                                 input logic [2:0] synd, input int exp_lat);
      int lat;
      wait_valid(40, lat);
      if (exp_lat > 0) check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_word"}, switch_error, word);
      check_val({tag, "_synd"}, sindrome, synd);
      check_val({tag, "_err"}, error_detected, |synd);
      if (ready) begin
         @(posedge clk);
         #1;
         check_val({tag, "_pulse"}, valid, 1'b0);
      end
   endtask

   task automatic apply_word(input string tag, input logic [6:0] word, input logic [2:0] synd);
      switch_raw = word;
      expect_capture(tag, word, synd, LATENCY);
   endtask

   initial begin
      int lat;
      int nvalid;

      // Test 1: reset values, then the mandatory first emit of 0.
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_valid", valid, 1'b0);
      check_val("rst_word", switch_error, 7'b0);
      check_val("rst_synd", sindrome, 3'b0);
      check_val("rst_err", error_detected, 1'b0);
      rst_n = 1'b1;
      wait_valid(LATENCY, lat);
      check_val("first_in_window", (lat >= 1) && (lat <= LATENCY), 1'b1);
      check_val("first_word", switch_error, 7'b0);
      check_val("first_synd", sindrome, 3'b000);
      check_val("first_err", error_detected, 1'b0);
      @(posedge clk);
      #1;
      check_val("first_pulse", valid, 1'b0);

      // Tests 2 and 3: codeword and single-bit errors.
      apply_word("cw_all1", 7'b1111111, 3'b000);
      apply_word("err_pos3", 7'b0000100, 3'b011);
      apply_word("err_pos7", 7'b1000000, 3'b111);

      // Test 4: bouncing bit 4 never emits; the settled value emits once.
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         switch_raw = (i % 2 == 0) ? 7'b0010000 : 7'b0000000;
         repeat (2) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
         end
      end
      check_val("bounce_no_valid", nvalid, 0);
      apply_word("bounce_final", 7'b0010000, 3'b101);
      nvalid = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (valid) nvalid++;
      end
      check_val("bounce_single", nvalid, 0);

      // Test 5: hold with ready low, then handshake and the queued change.
      ready = 1'b0;
      apply_word("hold_cap", 7'b0100000, 3'b110);
      switch_raw = 7'b0000001;
      repeat (12) @(posedge clk);
      #1;
      check_val("hold_valid", valid, 1'b1);
      check_val("hold_word", switch_error, 7'b0100000);
      check_val("hold_synd", sindrome, 3'b110);
      ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("ack_drop", valid, 1'b0);
      expect_capture("after_ack", 7'b0000001, 3'b001, DEBOUNCE_CYCLES + 1);

      // Test 6: error counter sequence and asynchronous reset during hold.
      rst_n = 1'b0;
      #1;
      check_val("areset_clr_word", switch_error, 7'b0);
      switch_raw = 7'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_capture("rerun_first", 7'b0, 3'b000, 0);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_0", error_count, 2'd0);
`endif
      apply_word("ec1", 7'b0000001, 3'b001);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_1", error_count, 2'd1);
`endif
      apply_word("ec2", 7'b0000010, 3'b010);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_2", error_count, 2'd2);
`endif
      apply_word("ec3", 7'b0000100, 3'b011);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_3", error_count, 2'd3);
`endif
      apply_word("ec4", 7'b0001000, 3'b100);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_sat4", error_count, 2'd3);
`endif
      apply_word("ec5", 7'b0010000, 3'b101);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("ecnt_sat5", error_count, 2'd3);
`endif
      ready = 1'b0;
      apply_word("pre_rst_hold", 7'b0100000, 3'b110);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_hold_valid", valid, 1'b0);
      check_val("rst_hold_synd", sindrome, 3'b000);
`ifdef HAMMING_ERROR_COUNT_EN
      check_val("rst_hold_ecnt", error_count, 2'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
